// File: rtl/mig_app_model.sv
`default_nettype none
// ============================================================================
//  Module      : mig_app_model
//  Description : Cycle-level behavioural responder for the 7-series MIG user
//                (app_*) interface. Backs commands with an internal 128-bit
//                line memory and models calibration delay, command/write-data
//                decoupling, fixed read latency and periodic refresh stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module mig_app_model #(
  parameter int AWIDTH       = 10,
  parameter int RD_LAT       = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int REF_PERIOD   = 256,
  parameter int REF_CYCLES   = 8
) (
  input  logic         mclk,
  input  logic         mrst_n,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic         err_flag
);

  localparam int c_cal_w = $clog2(CALIB_CYCLES + 1);
  localparam int c_ref_w = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [2:0] c_CMD_WR = 3'b000;
  localparam logic [2:0] c_CMD_RD = 3'b001;

  // Backing store; deliberately not reset so contents survive a reset.
  logic [127:0]        r_mem [2**AWIDTH];

  logic [c_cal_w-1:0]  r_calib_cnt;
  logic                r_calib;
  logic [c_ref_w-1:0]  r_ref_cnt;
  logic                w_ref_stall;

  // Write-data FIFO: {mask, data} per entry.
  logic [143:0]        r_fifo [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;
  logic [143:0]        w_head;

  logic                r_wpend_valid;
  logic [AWIDTH-1:0]   r_wpend_line;

  logic                r_rd_vld [RD_LAT];
  logic [127:0]        r_rd_dat [RD_LAT];

  logic                r_err;

  logic [AWIDTH-1:0]   w_line;
  logic                w_cmd_acc;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_illegal;
  logic                w_push;
  logic                w_pop;
  logic                w_commit;
  logic                w_unused;

  // Address bits above the line index alias onto the same memory.
  assign w_unused  = &{1'b0, app_addr[27:AWIDTH+3]};
  assign w_line    = app_addr[AWIDTH+2:3];
  assign w_head    = r_fifo[r_rptr];

  assign w_commit  = r_wpend_valid && (r_count != 2'd0);
  assign w_pop     = w_commit;

  assign app_rdy     = r_calib && !w_ref_stall && !r_wpend_valid && !w_commit;
  assign app_wdf_rdy = r_calib && (r_count < 2'd2);

  assign w_cmd_acc = app_en && app_rdy;
  assign w_wr_acc  = w_cmd_acc && (app_cmd == c_CMD_WR);
  assign w_rd_acc  = w_cmd_acc && (app_cmd == c_CMD_RD);
  assign w_illegal = (app_cmd != c_CMD_WR) && (app_cmd != c_CMD_RD);
  assign w_push    = app_wdf_wren && app_wdf_rdy;

  assign init_calib_complete = r_calib;
  assign err_flag            = r_err;
  assign app_rd_data_valid   = r_rd_vld[RD_LAT-1];
  assign app_rd_data_end     = r_rd_vld[RD_LAT-1];
  assign app_rd_data         = r_rd_vld[RD_LAT-1] ? r_rd_dat[RD_LAT-1] : '0;

  // Calibration timer: completion is registered on the CALIB_CYCLES-th edge.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_calib_cnt <= '0;
      r_calib     <= 1'b0;
    end else if (!r_calib) begin
      if (r_calib_cnt == c_cal_w'(CALIB_CYCLES - 1)) begin
        r_calib <= 1'b1;
      end else begin
        r_calib_cnt <= r_calib_cnt + 1'b1;
      end
    end
  end

  generate
    if (REF_PERIOD > 0) begin : g_ref
      // Free-running refresh phase counter, started at calibration done.
      always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
          r_ref_cnt <= '0;
        end else if (r_calib) begin
          if (r_ref_cnt == c_ref_w'(REF_PERIOD - 1)) begin
            r_ref_cnt <= '0;
          end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
          end
        end
      end
      assign w_ref_stall = r_calib && (r_ref_cnt < c_ref_w'(REF_CYCLES));
    end else begin : g_no_ref
      assign r_ref_cnt   = '0;
      assign w_ref_stall = 1'b0;
    end
  endgenerate

  // Write-data FIFO pointers, occupancy and storage.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {app_wdf_mask, app_wdf_data};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Single outstanding write command waiting for its data beat.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_wpend_valid <= 1'b0;
      r_wpend_line  <= '0;
    end else if (w_wr_acc) begin
      r_wpend_valid <= 1'b1;
      r_wpend_line  <= w_line;
    end else if (w_commit) begin
      r_wpend_valid <= 1'b0;
    end
  end

  // Byte-masked commit of the FIFO head into the pending line.
  always_ff @(posedge mclk) begin
    if (w_commit) begin
      for (int b = 0; b < 16; b++) begin
        if (!w_head[128+b]) begin
          r_mem[r_wpend_line][8*b +: 8] <= w_head[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: memory is sampled at acceptance and delayed RD_LAT cycles.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_rd_vld[i] <= 1'b0;
        r_rd_dat[i] <= '0;
      end
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      r_rd_dat[0] <= w_rd_acc ? r_mem[w_line] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_dat[i] <= r_rd_dat[i-1];
      end
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_err <= 1'b0;
    end else if ((w_cmd_acc && (w_illegal || (app_addr[2:0] != 3'b000))) ||
                 (w_push && !app_wdf_end)) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mig_app_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mig_app_model
//  Description : Directed self-checking bench for mig_app_model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_app_model;

  localparam int RD_LAT = 4;

  logic         mclk = 1'b0;
  logic         mrst_n;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         err_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 mclk = ~mclk;

  mig_app_model #(
    .AWIDTH(10), .RD_LAT(RD_LAT), .CALIB_CYCLES(64), .REF_PERIOD(256), .REF_CYCLES(8)
  ) dut (
    .mclk(mclk), .mrst_n(mrst_n),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
    .err_flag(err_flag)
  );

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int k = 0;
    while (!app_rdy && k < 2000) begin
      tick;
      k++;
    end
    if (!app_rdy) chk({tag, " rdy timeout"}, app_rdy, 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr, input string tag);
    wait_rdy(tag);
    app_en   = 1'b1;
    app_cmd  = cmd;
    app_addr = addr;
    tick;
    app_en   = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] data, input logic [15:0] mask, input string tag);
    int k = 0;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = data;
    app_wdf_mask = mask;
    while (!app_wdf_rdy && k < 2000) begin
      tick;
      k++;
    end
    if (!app_wdf_rdy) chk({tag, " wdf timeout"}, app_wdf_rdy, 1'b1);
    tick;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  task automatic read_check(input logic [27:0] addr, input logic [127:0] exp, input string tag);
    int k = 0;
    send_cmd(3'b001, addr, tag);
    while (!app_rd_data_valid && k < 20) begin
      tick;
      k++;
    end
    chk({tag, " latency"}, k, RD_LAT - 1);
    chk({tag, " data"}, app_rd_data, exp);
    chk({tag, " end"}, app_rd_data_end, 1'b1);
  endtask

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D3 = 128'h00112233_44556677_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
  localparam logic [127:0] DA = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] DB = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] DC = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

  initial begin
    logic [27:0]  addrs [4];
    logic [127:0] vals  [4];
    logic [127:0] q [$];
    logic [127:0] e;
    int issued, received, bad, low, run, maxrun, nvalid;

    mrst_n       = 1'b0;
    app_addr     = '0;
    app_cmd      = 3'b000;
    app_en       = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;

    // 1. Reset state and calibration timing
    repeat (3) tick;
    chk("rst app_rdy", app_rdy, 1'b0);
    chk("rst wdf_rdy", app_wdf_rdy, 1'b0);
    chk("rst valid", app_rd_data_valid, 1'b0);
    chk("rst end", app_rd_data_end, 1'b0);
    chk("rst calib", init_calib_complete, 1'b0);
    chk("rst err", err_flag, 1'b0);
    chk("rst rd_data", app_rd_data, 128'h0);
    @(negedge mclk);
    mrst_n = 1'b1;
    repeat (63) tick;
    chk("calib before 64", init_calib_complete, 1'b0);
    chk("rdy before calib", app_rdy, 1'b0);
    chk("wdf_rdy before calib", app_wdf_rdy, 1'b0);
    tick;
    chk("calib at 64", init_calib_complete, 1'b1);
    chk("wdf_rdy at calib", app_wdf_rdy, 1'b1);
    chk("rdy in first refresh", app_rdy, 1'b0);
    repeat (7) tick;
    chk("rdy refresh cycle 7", app_rdy, 1'b0);
    tick;
    chk("rdy after refresh", app_rdy, 1'b1);

    // 2. Full write then read back
    send_beat(D1, 16'h0000, "t2 beat");
    send_cmd(3'b000, 28'h40, "t2 wr");
    chk("t2 rdy low while committing", app_rdy, 1'b0);
    read_check(28'h40, D1, "t2 rd");
    tick;
    chk("t2 valid drops", app_rd_data_valid, 1'b0);
    chk("t2 data zero", app_rd_data, 128'h0);

    // 3. Masked write
    send_beat({128{1'b1}}, 16'hFF00, "t3 beat");
    send_cmd(3'b000, 28'h40, "t3 wr");
    read_check(28'h40, D3, "t3 rd");

    // 4. Command ahead of data, data delayed 5 cycles
    send_cmd(3'b000, 28'h40, "t4 wr");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4 rdy pending %0d", i), app_rdy, 1'b0);
      tick;
    end
    send_beat(D4, 16'h0000, "t4 beat");
    read_check(28'h40, D4, "t4 rd");

    // 5. Three beats with no commands
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_mask = 16'h0000;
    app_wdf_data = DA;
    tick;
    app_wdf_data = DB;
    tick;
    chk("t5 wdf_rdy full", app_wdf_rdy, 1'b0);
    app_wdf_data = DC;
    repeat (3) tick;
    chk("t5 wdf_rdy held", app_wdf_rdy, 1'b0);
    send_cmd(3'b000, 28'h100, "t5 wrA");
    chk("t5 wdf_rdy during pop", app_wdf_rdy, 1'b0);
    tick;
    chk("t5 wdf_rdy after pop", app_wdf_rdy, 1'b1);
    tick;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    chk("t5 wdf_rdy refilled", app_wdf_rdy, 1'b0);
    send_cmd(3'b000, 28'h110, "t5 wrB");
    send_cmd(3'b000, 28'h120, "t5 wrC");
    read_check(28'h100, DA, "t5 rdA");
    read_check(28'h110, DB, "t5 rdB");
    read_check(28'h120, DC, "t5 rdC");
    repeat (RD_LAT + 1) tick;

    // 6. Streamed reads across refresh windows
    addrs[0] = 28'h40;  vals[0] = D4;
    addrs[1] = 28'h100; vals[1] = DA;
    addrs[2] = 28'h110; vals[2] = DB;
    addrs[3] = 28'h120; vals[3] = DC;
    issued = 0; received = 0; bad = 0; low = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 512; c++) begin
      if (issued < 300) begin
        app_en   = 1'b1;
        app_cmd  = 3'b001;
        app_addr = addrs[issued % 4];
      end else begin
        app_en = 1'b0;
      end
      if (!app_rdy) begin
        low++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (app_en && app_rdy) begin
        q.push_back(vals[issued % 4]);
        issued++;
      end
      tick;
      if (app_rd_data_valid) begin
        received++;
        if (q.size() == 0) begin
          bad++;
        end else begin
          e = q.pop_front();
          if (app_rd_data !== e) bad++;
        end
      end
    end
    app_en = 1'b0;
    chk("t6 issued", issued, 300);
    chk("t6 received", received, 300);
    chk("t6 data order", bad, 0);
    chk("t6 rdy low cycles per 512", low, 16);
    chk("t6 longest stall", maxrun, 8);

    // Address aliasing above the line index
    read_check(28'h2040, D4, "alias rd");
    repeat (RD_LAT + 1) tick;

    // Illegal command
    chk("err before illegal", err_flag, 1'b0);
    send_cmd(3'b010, 28'h40, "illegal");
    chk("err after illegal", err_flag, 1'b1);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      if (app_rd_data_valid) nvalid++;
      tick;
    end
    chk("illegal no data", nvalid, 0);

    // Reset during an in-flight read
    send_cmd(3'b001, 28'h40, "reset rd");
    tick;
    mrst_n = 1'b0;
    #1;
    chk("mid-reset valid", app_rd_data_valid, 1'b0);
    chk("mid-reset err", err_flag, 1'b0);
    chk("mid-reset calib", init_calib_complete, 1'b0);
    @(negedge mclk);
    mrst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (app_rd_data_valid) nvalid++;
    end
    chk("read discarded by reset", nvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
